ltc2333_scan_sequencer: RTL and testbench

Scan scheduler for the LTC2333 acquisition path. After a start request it issues one conversion scan every `sample_period` clocks, `n_reads` scans in total. Each scan emits one 8-bit SoftSpan control word per enabled channel, over a valid/ready stream to the ADC serializer. It sits between the IPIF parameter registers (active_channels, range, mode, sample_period, n_reads, reset/timetrig) and the serializer that drives `cnv`/`scki`/`sdi`, and returns `readInProgress` to the status register.

---
 rtl/ltc2333_scan_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_ltc2333_scan_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2333_scan_sequencer.sv
// rtl/ltc2333_scan_sequencer.sv - periodic LTC2333 scan scheduler emitting SoftSpan control words
module ltc2333_scan_sequencer #(
    parameter int N_CH = 8
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            start,
    input  logic            abort,
    input  logic [N_CH-1:0] active_channels,
    input  logic [2:0]      range,
    input  logic            mode,
    input  logic [31:0]     sample_period,
    input  logic [15:0]     n_reads,
    output logic [7:0]      word_data,
    output logic            word_valid,
    output logic            word_last,
    input  logic            word_ready,
    output logic            busy,
    output logic [15:0]     scan_count,
    output logic            overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            start_pend;
    logic            start_accept;
    logic [N_CH-1:0] cfg_mask;
    logic [2:0]      cfg_range;
    logic            cfg_mode;
    logic [31:0]     cfg_reload;
    logic [15:0]     cfg_n_reads;
    logic [31:0]     timer;

    logic            fire;
    logic            fire_last;
    logic            tick;
    logic [15:0]     count_next;
    logic            run_done;
    logic            begin_run;
    logic            load_first;
    logic            advance;
    logic            retire;
    logic            count_inc;
    logic            drop_tick;
    logic [2:0]      cur_ch;
    logic [2:0]      first_ch;
    logic [2:0]      next_ch;

    function automatic logic [2:0] first_set_from(input logic [N_CH-1:0] mask, input int from);
        logic [2:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic none_above(input logic [N_CH-1:0] mask, input int ch);
        logic found;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i] && i > ch) found = 1'b1;
        end
        return !found;
    endfunction

    assign cur_ch   = word_data[5:3];
    assign first_ch = first_set_from(cfg_mask, 0);
    assign next_ch  = first_set_from(cfg_mask, int'(cur_ch) + 1);

    assign fire       = word_valid & word_ready;
    assign fire_last  = fire & word_last;
    assign tick       = busy & (timer == 32'd0);
    assign count_next = scan_count + 16'd1;
    assign run_done   = fire_last & (count_next == cfg_n_reads);
    assign begin_run  = (state == S_IDLE) & start_pend & ~abort;

    // A start is captured one cycle ahead so busy and the first word rise together.
    assign start_accept = (state == S_IDLE) & ~start_pend & start & ~abort
                        & (|active_channels) & (|n_reads);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start_pend) state_next = S_SCAN;
                S_SCAN: begin
                    if (fire_last) begin
                        if (run_done)  state_next = S_IDLE;
                        else if (tick) state_next = S_SCAN;
                        else           state_next = S_WAIT;
                    end
                end
                S_WAIT: if (tick) state_next = S_SCAN;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        load_first = 1'b0;
        advance    = 1'b0;
        retire     = 1'b0;
        count_inc  = 1'b0;
        drop_tick  = 1'b0;
        if (abort) begin
            retire = 1'b1;
        end else begin
            case (state)
                S_IDLE: load_first = start_pend;
                S_SCAN: begin
                    advance    = fire & ~word_last;
                    count_inc  = fire_last;
                    retire     = fire_last;
                    load_first = fire_last & tick & ~run_done;
                    drop_tick  = tick & ~fire_last;
                end
                S_WAIT: load_first = tick;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            start_pend  <= 1'b0;
            cfg_mask    <= '0;
            cfg_range   <= '0;
            cfg_mode    <= 1'b0;
            cfg_reload  <= '0;
            cfg_n_reads <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            scan_count  <= '0;
            word_valid  <= 1'b0;
            word_last   <= 1'b0;
            word_data   <= '0;
        end else begin
            start_pend <= start_accept;
            busy       <= (state_next != S_IDLE);
            overrun    <= drop_tick;

            if (start_accept) begin
                cfg_mask    <= active_channels;
                cfg_range   <= range;
                cfg_mode    <= mode;
                cfg_reload  <= (sample_period == 32'd0) ? 32'd0 : sample_period - 32'd1;
                cfg_n_reads <= n_reads;
            end

            if (begin_run) begin
                scan_count <= '0;
            end else if (count_inc) begin
                scan_count <= count_next;
            end

            if (begin_run) begin
                timer <= cfg_reload;
            end else if (busy) begin
                timer <= tick ? cfg_reload : timer - 32'd1;
            end

            if (load_first) begin
                word_valid <= 1'b1;
                word_data  <= {1'b1, cfg_mode, first_ch, cfg_range};
                word_last  <= none_above(cfg_mask, int'(first_ch));
            end else if (advance) begin
                word_data  <= {1'b1, cfg_mode, next_ch, cfg_range};
                word_last  <= none_above(cfg_mask, int'(next_ch));
            end else if (retire) begin
                word_valid <= 1'b0;
                word_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ltc2333_scan_sequencer.sv
// tb/tb_ltc2333_scan_sequencer.sv - scoreboard bench for ltc2333_scan_sequencer
module tb_ltc2333_scan_sequencer;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  active_channels = '0;
    logic [2:0]  range = '0;
    logic        mode = 1'b0;
    logic [31:0] sample_period = '0;
    logic [15:0] n_reads = '0;
    logic        word_ready = 1'b0;
    logic [7:0]  word_data;
    logic        word_valid;
    logic        word_last;
    logic        busy;
    logic [15:0] scan_count;
    logic        overrun;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   run_e0 = 0;
    int   last_acc = 0;
    int   ovr_total = 0;
    int   ready_mode = 0;

    ltc2333_scan_sequencer #(.N_CH(8)) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .start           (start),
        .abort           (abort),
        .active_channels (active_channels),
        .range           (range),
        .mode            (mode),
        .sample_period   (sample_period),
        .n_reads         (n_reads),
        .word_data       (word_data),
        .word_valid      (word_valid),
        .word_last       (word_last),
        .word_ready      (word_ready),
        .busy            (busy),
        .scan_count      (scan_count),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) if (overrun) ovr_total <= ovr_total + 1;

    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       word_ready = 1'b1;
            1:       word_ready = ($urandom_range(0, 2) != 0);
            default: word_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        exp_t e;
        if (aresetn && word_valid && word_ready) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("word_data", word_data, e.data);
                check("word_last", word_last, e.last);
                if (e.acc >= 0) check("accept_edge", edge_cnt + 1 - run_e0, e.acc);
            end
            last_acc = edge_cnt + 1 - run_e0;
        end
    end

    // cut_kind: 0 none, 1 abort sampled at edge cut_at, 2 async reset after edge cut_at
    task automatic run(input logic [7:0] mask, input logic [2:0] rng, input logic md,
                       input int per, input int nr, input int rmode, input int cut_kind,
                       input int cut_at, input bit start_abort, input bit poke, input bit stall4);
        int   chs[$];
        int   k_ch, p, s, fin, n_ovr_exp, done_scans, ovr0, rel, fall, hold;
        bit   valid_cfg, timed, seen, finished;
        logic [2:0] c;
        logic [7:0] w0;
        exp_t e;

        for (int i = 0; i < 8; i++) if (mask[i]) chs.push_back(i);
        k_ch = chs.size();
        p = (per == 0) ? 1 : per;
        valid_cfg = (k_ch > 0) && (nr > 0) && !start_abort;
        timed = (rmode == 0) && !stall4;
        s = 1; fin = 0; n_ovr_exp = 0; done_scans = 0; w0 = '0;
        if (valid_cfg) begin
            for (int k = 0; k < nr; k++) begin
                for (int i = 0; i < k_ch; i++) begin
                    c = 3'(chs[i]);
                    e.data = {1'b1, md, c, rng};
                    e.last = (i == k_ch - 1);
                    e.acc  = timed ? s + i + 1 : -1;
                    if (k == 0 && i == 0) w0 = e.data;
                    if (cut_kind == 0 || s + i + 1 <= cut_at) exp_q.push_back(e);
                end
                fin = s + k_ch;
                if (cut_kind == 0 || fin < cut_at) done_scans++;
                for (int j = 1; 1 + j * p < fin; j++) if (1 + j * p > s) n_ovr_exp++;
                s = fin;
                while ((s - 1) % p != 0) s++;
            end
        end

        active_channels = mask; range = rng; mode = md;
        sample_period = per; n_reads = nr;
        ready_mode = stall4 ? 2 : rmode;
        ovr0 = ovr_total;
        @(posedge clk); #2;
        start = 1'b1; abort = start_abort; run_e0 = edge_cnt + 1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        // Scramble live configuration; the run must keep its latched copy.
        active_channels = 8'($urandom); range = 3'($urandom); mode = 1'($urandom);
        sample_period = $urandom_range(0, 7); n_reads = 16'($urandom_range(0, 9));

        seen = 0; fall = -1; hold = 0; finished = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            rel = edge_cnt - run_e0;
            start = poke && (rel == 5);
            if (busy) seen = 1;
            if (valid_cfg && rel == 0) check("busy_before_edge1", busy, 0);
            if (valid_cfg && rel == 1) check("first_valid_edge1", {busy, word_valid}, 2'b11);
            if (stall4 && rel >= 1 && rel <= 5 && word_valid && word_data == w0) hold++;
            if (stall4 && rel == 4) ready_mode = 0;
            if (!valid_cfg && rel >= 20) begin finished = 1; break; end
            if (cut_kind == 1 && rel == cut_at - 1) abort = 1'b1;
            if (cut_kind == 1 && rel == cut_at) begin
                abort = 1'b0;
                check("abort_outputs", {word_valid, busy}, 2'b00);
                check("abort_scan_count", scan_count, done_scans);
                finished = 1;
                break;
            end
            if (cut_kind == 2 && rel == cut_at) begin
                aresetn = 1'b0;
                #1;
                check("async_reset_outputs",
                      {word_valid, word_last, busy, overrun, word_data, scan_count}, 0);
                #3;
                aresetn = 1'b1;
                finished = 1;
                break;
            end
            if (seen && !busy) begin fall = rel; finished = 1; break; end
        end
        start = 1'b0;
        check("run_terminated", finished, 1);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        if (!valid_cfg) begin
            check("busy_never", seen, 0);
        end else if (cut_kind == 0) begin
            check("scan_count", scan_count, nr);
            check("busy_fall_vs_last_accept", fall, last_acc);
            if (stall4) check("stall_hold_cycles", hold, 5);
            if (timed) begin
                check("busy_fall_edge", fall, fin);
                check("overrun_count", ovr_total - ovr0, n_ovr_exp);
            end
        end
        exp_q.delete();
        ready_mode = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {word_valid, word_last, busy, overrun, word_data, scan_count}, 0);
        @(posedge clk); #2;
        aresetn = 1'b1;

        //   mask   rng   md    per nr rm cut at sa poke stall
        run(8'h05, 3'd3, 1'b0, 10, 3, 0, 0, 0, 0, 1, 0);
        run(8'h80, 3'd3, 1'b0, 10, 2, 0, 0, 0, 0, 0, 1);
        run(8'hFF, 3'd5, 1'b1,  4, 2, 0, 0, 0, 0, 0, 0);
        run(8'h00, 3'd1, 1'b0,  5, 3, 0, 0, 0, 0, 0, 0);
        run(8'h21, 3'd1, 1'b0,  5, 0, 0, 0, 0, 0, 0, 0);
        run(8'h01, 3'd6, 1'b1,  0, 4, 0, 0, 0, 0, 0, 0);
        run(8'h0F, 3'd2, 1'b0, 20, 3, 0, 1, 23, 0, 0, 0);
        run(8'h0F, 3'd2, 1'b1, 20, 2, 0, 0, 0, 0, 0, 0);
        run(8'h05, 3'd3, 1'b0, 10, 3, 0, 0, 0, 1, 0, 0);
        run(8'h01, 3'd4, 1'b0, 30, 3, 0, 2, 10, 0, 0, 0);
        run(8'h42, 3'd7, 1'b1,  3, 3, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 16; r++) begin
            run(8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 12), $urandom_range(1, 4), r % 2, 0, 0, 0, 0, 0);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
